wb_port_arbiter: RTL

Shares the single register-file write port between the in-order pipeline WB stage and one long-latency result source (multi-cycle MDU / late load), which connects through a valid/ready handshake.
Buffers long-latency results in a small FIFO and tracks in-flight destinations in a scoreboard so the decoder can detect hazards.
Bounds starvation of the long-latency source by stalling the pipeline WB.
Sits between the WB stage and the register file.

---
 rtl/wb_port_arbiter_pkg.sv | 27 ++
 rtl/wb_port_arbiter_if.sv | 52 +++++
 rtl/wb_result_fifo.sv | 48 ++++
 rtl/wb_port_arbiter.sv | 130 +++++++++++++
 4 files changed

// File: rtl/wb_port_arbiter_pkg.sv
// Shared types for the register-file write-port arbiter: data width, register
// index type and the write-request record carried by both result sources.
package wb_port_arbiter_pkg;

  localparam int XLEN = 32;

  typedef logic [4:0] regnum_t;

  typedef struct packed {
    logic            wen;
    regnum_t         wnum;
    logic [XLEN-1:0] wdata;
  } wb_req_t;

  typedef enum logic [1:0] {
    SRC_IDLE,
    SRC_PIPE,
    SRC_FIFO,
    SRC_LR
  } wb_src_e;

  // A request only touches the register file when enabled and not aimed at x0.
  function automatic logic is_live(input wb_req_t req);
    return req.wen && (req.wnum != '0);
  endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bus bundle between the WB stage / long-latency source / decoder / register
// file (master side) and the write-port arbiter (slave side).
interface wb_port_arbiter_if;
  import wb_port_arbiter_pkg::*;

  logic            pipe_wen;
  regnum_t         pipe_wnum;
  logic [XLEN-1:0] pipe_wdata;
  logic            pipe_stall;

  logic            lr_valid;
  logic            lr_ready;
  regnum_t         lr_wnum;
  logic [XLEN-1:0] lr_wdata;

  logic            sb_set;
  regnum_t         sb_set_num;

  regnum_t         rs1_num;
  regnum_t         rs2_num;
  regnum_t         rd_num;
  logic            rs1_busy;
  logic            rs2_busy;
  logic            rd_busy;

  logic            rf_wen;
  regnum_t         rf_wnum;
  logic [XLEN-1:0] rf_wdata;

  modport slave (
    input  pipe_wen, pipe_wnum, pipe_wdata,
    output pipe_stall,
    input  lr_valid, lr_wnum, lr_wdata,
    output lr_ready,
    input  sb_set, sb_set_num,
    input  rs1_num, rs2_num, rd_num,
    output rs1_busy, rs2_busy, rd_busy,
    output rf_wen, rf_wnum, rf_wdata
  );

  modport master (
    output pipe_wen, pipe_wnum, pipe_wdata,
    input  pipe_stall,
    output lr_valid, lr_wnum, lr_wdata,
    input  lr_ready,
    output sb_set, sb_set_num,
    output rs1_num, rs2_num, rd_num,
    input  rs1_busy, rs2_busy, rd_busy,
    input  rf_wen, rf_wnum, rf_wdata
  );

endinterface

// File: rtl/wb_result_fifo.sv
// Small synchronous FIFO of write requests with a combinational head so the
// arbiter can grant the oldest buffered result in the cycle it is visible.
module wb_result_fifo
  import wb_port_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  wb_req_t push_data,
  input  logic    pop,
  output wb_req_t head,
  output logic    full,
  output logic    empty
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one wrap bit so full and empty are distinguishable.
  logic [AW:0] wr_ptr_reg;
  logic [AW:0] rd_ptr_reg;
  wb_req_t     mem_reg [0:DEPTH-1];
  logic        push_ok;
  logic        pop_ok;

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign head    = mem_reg[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_reg[wr_ptr_reg[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline WB vs. buffered long-latency
// results, with starvation guard and pending-register scoreboard. WB_BYPASS_EN
// enables a zero-latency path for long-latency results when the port is free.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  wb_port_arbiter_if.slave  bus
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  wb_req_t         pipe_req;
  wb_req_t         lr_req;
  wb_req_t         fifo_head;
  wb_req_t         sel_req;
  wb_src_e         src;
  logic            fifo_full;
  logic            fifo_empty;
  logic            fifo_push;
  logic            fifo_pop;
  logic            bypass_ok;
  logic            rf_write;
  logic            lr_clr;
  regnum_t         rf_wnum;
  logic [CW-1:0]   starve_reg;
  logic [CW-1:0]   starve_next;
  logic            force_reg;
  logic            force_next;
  logic [31:0]     pend_reg;
  logic [31:0]     pend_next;

  assign pipe_req = '{wen: bus.pipe_wen, wnum: bus.pipe_wnum, wdata: bus.pipe_wdata};
  assign lr_req   = '{wen: bus.lr_valid, wnum: bus.lr_wnum,   wdata: bus.lr_wdata};

  wb_result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (lr_req),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

`ifdef WB_BYPASS_EN
  assign bypass_ok = fifo_empty && bus.lr_valid && !force_reg;
`else
  assign bypass_ok = 1'b0;
`endif

  // Grant priority: forced drain, then pipeline, then buffered result, then bypass.
  always_comb begin
    src = SRC_IDLE;
    if (rst_n) begin
      if (force_reg && !fifo_empty)  src = SRC_FIFO;
      else if (is_live(pipe_req))    src = SRC_PIPE;
      else if (!fifo_empty)          src = SRC_FIFO;
      else if (bypass_ok)            src = SRC_LR;
    end
  end

  always_comb begin
    sel_req = '0;
    case (src)
      SRC_PIPE: sel_req = pipe_req;
      SRC_FIFO: sel_req = fifo_head;
      SRC_LR:   sel_req = lr_req;
      default:  sel_req = '0;
    endcase
  end

  assign rf_write      = is_live(sel_req);
  assign rf_wnum       = rf_write ? sel_req.wnum : '0;
  assign bus.rf_wen    = rf_write;
  assign bus.rf_wnum   = rf_wnum;
  assign bus.rf_wdata  = rf_write ? sel_req.wdata : '0;

  assign lr_clr        = rf_write && ((src == SRC_FIFO) || (src == SRC_LR));
  assign fifo_pop      = (src == SRC_FIFO);
  assign fifo_push     = rst_n && bus.lr_valid && !fifo_full && (src != SRC_LR);
  assign bus.lr_ready  = !fifo_full;
  assign bus.pipe_stall = force_reg && !fifo_empty;

  always_comb begin
    starve_next = starve_reg;
    if (fifo_pop || fifo_empty)
      starve_next = '0;
    else if ((src == SRC_PIPE) && (starve_reg != CW'(STARVE_MAX)))
      starve_next = starve_reg + CW'(1);

    force_next = force_reg;
    if (fifo_pop)
      force_next = 1'b0;
    else if (starve_next == CW'(STARVE_MAX))
      force_next = 1'b1;
  end

  // Per-register pending bits; a new issue wins over a same-cycle retirement.
  for (genvar gi = 0; gi < 32; gi++) begin : g_pend
    if (gi == 0) begin : g_x0
      assign pend_next[gi] = 1'b0;
    end else begin : g_xn
      assign pend_next[gi] = (bus.sb_set && (bus.sb_set_num == 5'(gi))) ||
                             (pend_reg[gi] && !(lr_clr && (rf_wnum == 5'(gi))));
    end
  end

  assign bus.rs1_busy = pend_reg[bus.rs1_num];
  assign bus.rs2_busy = pend_reg[bus.rs2_num];
  assign bus.rd_busy  = pend_reg[bus.rd_num];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_reg <= '0;
      force_reg  <= 1'b0;
      pend_reg   <= '0;
    end else begin
      starve_reg <= starve_next;
      force_reg  <= force_next;
      pend_reg   <= pend_next;
    end
  end

endmodule
